// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants and types for the control register bank
// and its write arbiter.
//   DEF_NUM_REGS / DEF_ADDR_W / DEF_DATA_W : default bank geometry
//   arb_state_t                            : grant FSM state encoding
package reg_bank_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select.
//   req        : request vector, one bit per requester
//   last_owner : previous grant; the search starts at last_owner+1 and wraps
//   winner     : index of the first requester found (0 when none)
//   found      : high when any request bit is set
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GID_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last_owner,
  output logic [GID_W-1:0]   winner,
  output logic               found
);

  // Outer loop walks the circular priority order; inner loop keeps every
  // bit select on a constant index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && ((32'(last_owner) + off) % NUM_REQ == i)) begin
          found  = 1'b1;
          winner = GID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: owns the NUM_REGS x DATA_W control register bank and
// shares its single write port between NUM_REQ requesters with a
// round-robin grant FSM (IDLE/OWNED). An owner may hold the grant with
// req_lock for burst writes; a locked but idle owner is released after
// LOCK_TIMEOUT cycles (0 = never).
//
// Ports:
//   clock, reset      : clock, asynchronous active-high reset
//   req_valid/lock    : per-requester write request / keep-grant flag
//   req_addr/data     : packed per-requester address and data
//   req_ready         : one-hot ready for the current owner while OWNED
//   grant_id          : current or last owner
//   wr_strobe/wr_addr : one-cycle pulse and address of each committed write
//   wr_err            : one-cycle pulse when a handshaked write is dropped
//   registers_packed  : whole bank, register i at [i*DATA_W +: DATA_W]
//
// Build option: REG_WRITE_PROTECT_EN makes registers flagged in RO_MASK
// read-only to every requester except requester 0.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int                  NUM_REQ      = 2,
  parameter int                  NUM_REGS     = DEF_NUM_REGS,
  parameter int                  ADDR_W       = DEF_ADDR_W,
  parameter int                  DATA_W       = DEF_DATA_W,
  parameter int                  LOCK_TIMEOUT = 64,
  parameter logic [NUM_REGS-1:0] RO_MASK      = '0,
  parameter int                  GID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [GID_W-1:0]           grant_id,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       wr_err,
  output logic [NUM_REGS*DATA_W-1:0] registers_packed
);

  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  arb_state_t                 state;
  logic [GID_W-1:0]           owner;
  logic [GID_W-1:0]           last_owner;
  logic [CNT_W-1:0]           idle_cnt;
  logic [NUM_REGS*DATA_W-1:0] bank;

  logic                       sel_valid;
  logic                       sel_lock;
  logic [ADDR_W-1:0]          sel_addr;
  logic [DATA_W-1:0]          sel_data;
  logic [GID_W-1:0]           rr_winner;
  logic                       rr_found;
  logic                       hs;
  logic                       addr_ok;
  logic                       ro_hit;
  logic                       commit;
  logic                       drop;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_rr (
    .req        (req_valid),
    .last_owner (last_owner),
    .winner     (rr_winner),
    .found      (rr_found)
  );

  // Current owner's request fields.
  always_comb begin
    sel_valid = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == GID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_lock  = req_lock[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == OWNED) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (owner == GID_W'(i));
      end
    end
  end

`ifdef REG_WRITE_PROTECT_EN
  always_comb begin
    ro_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (sel_addr == ADDR_W'(i)) ro_hit = RO_MASK[i] && (owner != '0);
    end
  end
`else
  logic unused_ro_mask;
  assign unused_ro_mask = ^RO_MASK;
  assign ro_hit         = 1'b0;
`endif

  assign hs      = (state == OWNED) && sel_valid;
  assign addr_ok = int'(sel_addr) < NUM_REGS;
  assign commit  = hs && addr_ok && !ro_hit;
  assign drop    = hs && !commit;

  assign grant_id         = owner;
  assign registers_packed = bank;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= GID_W'(NUM_REQ - 1);
      idle_cnt   <= '0;
      bank       <= '0;
      wr_strobe  <= 1'b0;
      wr_err     <= 1'b0;
      wr_addr    <= '0;
    end else begin
      wr_strobe <= commit;
      wr_err    <= drop;
      if (commit) begin
        wr_addr <= sel_addr;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (sel_addr == ADDR_W'(i)) bank[i*DATA_W +: DATA_W] <= sel_data;
        end
      end

      case (state)
        IDLE: begin
          if (rr_found) begin
            owner      <= rr_winner;
            last_owner <= rr_winner;
            idle_cnt   <= '0;
            state      <= OWNED;
          end
        end
        OWNED: begin
          if (hs) begin
            idle_cnt <= '0;
            if (!sel_lock) state <= IDLE;
          end else if (!sel_lock) begin
            idle_cnt <= '0;
            state    <= IDLE;
          end else if (LOCK_TIMEOUT != 0 && idle_cnt == CNT_LAST) begin
            // This edge is the LOCK_TIMEOUT-th idle cycle of the lock.
            idle_cnt <= '0;
            state    <= IDLE;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

  localparam int NR    = 2;
  localparam int NREGS = 24;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int LTO   = 8;
  localparam logic [NREGS-1:0] ROM = 24'h000020;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_lock  = '0;
  logic [NR*AW-1:0]    req_addr  = '0;
  logic [NR*DW-1:0]    req_data  = '0;
  logic [NR-1:0]       req_ready;
  logic [0:0]          grant_id;
  logic                wr_strobe;
  logic [AW-1:0]       wr_addr;
  logic                wr_err;
  logic [NREGS*DW-1:0] registers_packed;

  reg_bank_arbiter #(
    .NUM_REQ      (NR),
    .NUM_REGS     (NREGS),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .LOCK_TIMEOUT (LTO),
    .RO_MASK      (ROM)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_lock         (req_lock),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .grant_id         (grant_id),
    .wr_strobe        (wr_strobe),
    .wr_addr          (wr_addr),
    .wr_err           (wr_err),
    .registers_packed (registers_packed)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int n_strobe = 0;
  int n_err = 0;

  // Reference model: grant holder, round-robin pointer, idle cycles, bank.
  bit          m_owned = 0;
  int          m_owner = 0;
  int          m_last = NR - 1;
  int          m_cnt = 0;
  logic [7:0]  m_bank [NREGS];
  logic [4:0]  m_wr_addr = '0;

  typedef struct {
    bit         err;
    logic [4:0] addr;
  } ev_t;
  ev_t sb [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_owned   = 0;
    m_owner   = 0;
    m_last    = NR - 1;
    m_cnt     = 0;
    m_wr_addr = '0;
    for (int i = 0; i < NREGS; i++) m_bank[i] = '0;
    sb.delete();
  endfunction

  function automatic void model_step();
    if (m_owned) begin
      logic [4:0] a;
      logic [7:0] d;
      bit v, l, bad;
      a = req_addr[m_owner*AW +: AW];
      d = req_data[m_owner*DW +: DW];
      v = req_valid[m_owner];
      l = req_lock[m_owner];
      if (v) begin
        bad = (a >= NREGS);
`ifdef REG_WRITE_PROTECT_EN
        if (!bad && m_owner != 0 && ROM[a]) bad = 1;
`endif
        if (bad) sb.push_back('{1'b1, a});
        else begin
          m_bank[a] = d;
          m_wr_addr = a;
          sb.push_back('{1'b0, a});
        end
        if (l) m_cnt = 0;
        else m_owned = 0;
      end else if (!l) begin
        m_owned = 0;
      end else begin
        m_cnt++;
        if (m_cnt == LTO) begin
          m_owned = 0;
          m_cnt = 0;
        end
      end
    end else if (req_valid != 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (req_valid[c]) begin
          m_owner = c;
          break;
        end
      end
      m_last  = m_owner;
      m_owned = 1;
      m_cnt   = 0;
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Monitor: compares outputs each cycle and pops the scoreboard on pulses.
  initial begin
    forever begin
      logic [NREGS*DW-1:0] exp_pk;
      logic [NR-1:0]       exp_rdy;
      ev_t e;
      @(negedge clock);
      exp_rdy = m_owned ? NR'(1 << m_owner) : '0;
      for (int i = 0; i < NREGS; i++) exp_pk[i*DW +: DW] = m_bank[i];
      chk("req_ready", req_ready, exp_rdy);
      chk("grant_id", grant_id, m_owner);
      chk("registers_packed", registers_packed, exp_pk);
      chk("wr_addr_hold", wr_addr, m_wr_addr);
      if (wr_strobe === 1'b1) n_strobe++;
      if (wr_err === 1'b1) n_err++;
      if (wr_strobe === 1'b1 || wr_err === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got strobe=%b err=%b expected none", wr_strobe, wr_err);
        end else begin
          e = sb.pop_front();
          chk("wr_err", wr_err, e.err);
          chk("wr_strobe", wr_strobe, !e.err);
          if (!e.err) chk("wr_addr", wr_addr, e.addr);
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: got none expected err=%b addr=%0d", e.err, e.addr);
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clock);
    #1;
    req_valid = v;
    req_lock  = l;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [7:0] reg_at(input int i);
    return registers_packed[i*DW +: DW];
  endfunction

  initial begin
    int ready1_cnt, grant0_at, e0, s0;
    logic [1:0] rv, rl;

    // Reset values
    hold(2);
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_err", wr_err, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_bank", registers_packed, '0);
    reset = 1'b0;

    // Both request: requester 0 first, then requester 1
    s0 = n_strobe;
    drive(2'b11, 2'b00, 5'd3, 5'd7, 8'hA5, 8'h5A);
    hold(3);
    drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    hold(2);
    chk("rr_reg3", reg_at(3), 8'hA5);
    chk("rr_reg7", reg_at(7), 8'h5A);
    chk("rr_strobes", n_strobe - s0, 2);

    // Locked burst from requester 1 while requester 0 waits
    drive(2'b10, 2'b10, 5'd9, 5'd0, 8'h77, 8'h11);
    drive(2'b11, 2'b10, 5'd9, 5'd0, 8'h77, 8'h11);
    drive(2'b11, 2'b10, 5'd9, 5'd1, 8'h77, 8'h22);
    drive(2'b11, 2'b10, 5'd9, 5'd2, 8'h77, 8'h33);
    drive(2'b11, 2'b00, 5'd9, 5'd3, 8'h77, 8'h44);
    drive(2'b01, 2'b00, 5'd9, 5'd3, 8'h77, 8'h44);
    drive(2'b01, 2'b00, 5'd9, 5'd3, 8'h77, 8'h44);
    drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    hold(2);
    chk("burst_regs", registers_packed[4*DW-1:0], 32'h44332211);
    chk("burst_reg9", reg_at(9), 8'h77);

    // Lock held with valid low: released after LTO idle cycles
    drive(2'b10, 2'b10, 5'd12, 5'd4, 8'hC3, 8'h00);
    ready1_cnt = 0;
    grant0_at = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (req_ready == 2'b10) ready1_cnt++;
      if (req_ready == 2'b01 && grant0_at < 0) grant0_at = i;
      if (i == 0) begin
        #1;
        req_valid = 2'b01;
      end
    end
    drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    hold(3);
    chk("timeout_cycles", ready1_cnt, LTO);
    chk("timeout_regrant", grant0_at, LTO + 1);

    // Out-of-range address
    e0 = n_err;
    s0 = n_strobe;
    drive(2'b01, 2'b00, 5'd31, 5'd0, 8'hEE, 8'h00);
    hold(1);
    drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    hold(2);
    chk("oor_err", n_err - e0, 1);
    chk("oor_strobe", n_strobe - s0, 0);

    // Write protect on register 5
    e0 = n_err;
    drive(2'b10, 2'b00, 5'd0, 5'd5, 8'h00, 8'hFF);
    hold(1);
    drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    hold(2);
`ifdef REG_WRITE_PROTECT_EN
    chk("ro_reg5_blocked", reg_at(5), 8'h00);
    chk("ro_err", n_err - e0, 1);
`else
    chk("ro_reg5_open", reg_at(5), 8'hFF);
    chk("ro_err", n_err - e0, 0);
`endif
    drive(2'b01, 2'b00, 5'd5, 5'd0, 8'h3C, 8'h00);
    hold(1);
    drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    hold(2);
    chk("ro_reg5_req0", reg_at(5), 8'h3C);

    // Reset mid-burst after two writes
    drive(2'b01, 2'b01, 5'd10, 5'd0, 8'h01, 8'h00);
    drive(2'b01, 2'b01, 5'd10, 5'd0, 8'h01, 8'h00);
    drive(2'b01, 2'b01, 5'd11, 5'd0, 8'h02, 8'h00);
    @(negedge clock);
    chk("pre_rst_reg11", reg_at(11), 8'h02);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_bank", registers_packed, '0);
    chk("mid_rst_ready", req_ready, 2'b00);
    chk("mid_rst_strobe", wr_strobe, 1'b0);
    chk("mid_rst_grant", grant_id, 1'b0);
    req_valid = '0;
    req_lock  = '0;
    hold(2);
    #1;
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rv = 2'($urandom);
      rl = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      drive(rv, rl, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            8'($urandom), 8'($urandom));
    end
    drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    hold(LTO + 4);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Owns the 32×8 control register bank and shares its single write port between several requesters, such as the I2C slave and local status/IO writers. A round-robin grant FSM accepts one write per handshake. Owners doing auto-increment bursts can lock the grant, and an idle-timeout reclaims a grant that is locked but idle. The full bank is exported as `registers_packed` to the IO/PWM datapath.

## Interface
- `NUM_REQ`, 2: number of write requesters (≥1).
- `NUM_REGS`, 32: number of 8-bit registers.
- `ADDR_W`, 5: address width; requires 2^ADDR_W ≥ NUM_REGS.
- `DATA_W`, 8: register width.
- `LOCK_TIMEOUT`, 64: idle cycles before a locked owner is forcibly released; 0 disables the timeout.
- `RO_MASK`, '0: NUM_REGS-bit mask; bit i set marks register i read-only to requesters ≠0. Used only with the macro.

Ports:
- `clock` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input NUM_REQ: per-requester write request.
- `req_lock` input NUM_REQ: owner keeps the grant after a write.
- `req_addr` input NUM_REQ*ADDR_W: requester i uses `[i*ADDR_W +: ADDR_W]`.
- `req_data` input NUM_REQ*DATA_W: requester i uses `[i*DATA_W +: DATA_W]`.
- `req_ready` output NUM_REQ: one-hot or zero; high only for the current owner while in OWNED.
- `grant_id` output $clog2(NUM_REQ) (min 1): current or last owner.
- `wr_strobe` output 1: one-cycle pulse after each committed write.
- `wr_addr` output ADDR_W: address of the last committed write.
- `wr_err` output 1: one-cycle pulse when a handshaked write was dropped.
- `registers_packed` output NUM_REGS*DATA_W: register i at `[i*DATA_W +: DATA_W]`.

## Operation
- FSM states: IDLE, OWNED.
- IDLE:
  - If any `req_valid` is high, the round-robin winner (search starts at last_owner+1, wrapping) becomes owner, and the state goes to OWNED.
  - Otherwise the FSM stays in IDLE.
- OWNED: `req_ready[owner]`=1, driven combinationally from state/owner. A handshake is `req_valid[owner] & req_ready[owner]` at a posedge.
  - On handshake, the write commits: `registers[addr] <= data`.
    - Address ≥ NUM_REGS: write dropped, `wr_err` pulses, no `wr_strobe`.
  - After a handshake with `req_lock[owner]`=1: stay OWNED and clear the idle counter.
  - After a handshake with `req_lock[owner]`=0: go to IDLE.
  - With no handshake and both `req_valid[owner]` and `req_lock[owner]` low: release to IDLE, no write.
  - With no handshake but lock high: the idle counter increments. When it reaches LOCK_TIMEOUT (≠0), the grant is released to IDLE.
- Last-owner pointer updates on every grant. Any requester with valid held is served within NUM_REQ grants, unless it is blocked by a lock that never times out.
- Non-owner requests are ignored; their `req_ready` is 0.
- Reset values:
  - all registers 0; state IDLE; idle counter 0.
  - last_owner = NUM_REQ-1, so requester 0 wins first.
  - `req_ready`, `wr_strobe`, `wr_err` = 0; `wr_addr`, `grant_id` = 0.

## Timing
- Grant latency: valid high before edge k in IDLE → OWNED after k → ready high in cycle k..k+1 → write at edge k+1.
- `registers_packed` and the `wr_strobe`/`wr_addr` pulse are visible after edge k+1.
- Unlocked throughput is 1 write per 2 cycles; a locked burst gives 1 write per cycle.
- Reset asserted mid-OWNED: immediate return to IDLE, bank cleared, pulses cancelled.
- A valid deasserted in the same cycle as grant: covered by the release rule at the next edge.
- Idle counter width is $clog2(LOCK_TIMEOUT+1), saturating; it has no wrap-around.

## Configuration
- `REG_WRITE_PROTECT_EN` defined:
  - A handshaked write from requester ≠0 to an address with `RO_MASK` bit set is dropped.
  - `wr_err` pulses and `wr_strobe` does not. The FSM transition is unchanged.
- Macro undefined: `RO_MASK` is ignored and all in-range writes commit. `wr_err` fires only for out-of-range addresses.

## Structure
- Package `reg_bank_pkg`:
  - default `NUM_REGS`/`ADDR_W`/`DATA_W` constants
  - `typedef enum logic {IDLE, OWNED} arb_state_t`
- One sub-module, `rr_arbiter`: combinational winner select from a request vector and a last-owner pointer. The FSM, counter and bank stay in `reg_bank_arbiter`.

## Test plan
- Reset then `req_valid`=2'b11 with lock 0, addr 3/7, data 8'hA5/8'h5A.
  - Requester 0 granted first: reg3=A5 at edge k+1.
  - Requester 1 next: reg7=5A two cycles later.
  - `wr_strobe` twice with `wr_addr` 3 then 7.
- Requester 1 locked burst of 4 writes to addr 0..3 (11,22,33,44) while requester 0 also requests.
  - 4 consecutive one-per-cycle writes from requester 1.
  - Requester 0 is granted only after lock drops.
- Requester 1 holds lock with valid low, `LOCK_TIMEOUT`=8.
  - Grant is released after exactly 8 idle cycles.
  - Pending requester 0 is granted on the next edge.
- Write to addr 31 with `NUM_REGS`=24.
  - `wr_err` pulses, no `wr_strobe`, bank unchanged.
- With `REG_WRITE_PROTECT_EN` and `RO_MASK[5]`=1:
  - requester 1 writes 8'hFF to reg5 → dropped with `wr_err`.
  - requester 0 writes 8'h3C to reg5 → commits.
- Reset asserted mid-burst after 2 writes.
  - `registers_packed` reads 0 immediately, `req_ready` is 0, state is IDLE.
